// File: rtl/stream_median_filter_if.sv
// rtl/stream_median_filter_if.sv - sample-in / rank-out handshake bundle; mode exists only with SMF_MODE_EN
interface stream_median_filter_if #(
  parameter int DW = 8
);
  logic [DW-1:0] Din;
  logic          in_en;
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] Dout;
`ifdef SMF_MODE_EN
  logic [1:0]    mode;

  modport master (output Din, in_en, mode, input busy, out_valid, Dout);
  modport slave  (input Din, in_en, mode, output busy, out_valid, Dout);
`else
  modport master (output Din, in_en, input busy, out_valid, Dout);
  modport slave  (input Din, in_en, output busy, out_valid, Dout);
`endif
endinterface

// File: rtl/stream_median_filter.sv
// rtl/stream_median_filter.sv - row-wise sliding rank filter with zero padding and H-cycle flush
// SMF_MODE_EN adds a mode input selecting median/min/max; otherwise the output is always the median.
module stream_median_filter #(
  parameter int DW  = 8,
  parameter int WIN = 7,
  parameter int LEN = 128
) (
  input logic                    clk,
  input logic                    reset,
  stream_median_filter_if.slave  bus
);
  localparam int H  = (WIN - 1) / 2;
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int FW = (H > 1) ? $clog2(H + 1) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fcnt;
  logic [DW-1:0] win [WIN];
  logic [DW-1:0] srt [WIN];

  logic [DW-1:0] shift_in;
  logic [DW-1:0] oldest;
  logic [DW-1:0] tmp  [WIN-1];
  logic [DW-1:0] nsrt [WIN];
  logic [DW-1:0] sel;
  int            r;
  int            p;

  // Next sorted copy: drop one instance of the oldest value, then insert the
  // incoming value after any equal entries so equal values keep arrival order.
  always_comb begin
    shift_in = (state == RUN) ? bus.Din : '0;
    oldest   = win[WIN-1];
    r = WIN - 1;
    for (int k = WIN - 1; k >= 0; k--) begin
      if (srt[k] == oldest) r = k;
    end
    for (int k = 0; k < WIN - 1; k++) begin
      tmp[k] = (k < r) ? srt[k] : srt[k+1];
    end
    p = 0;
    for (int k = 0; k < WIN - 1; k++) begin
      if (tmp[k] <= shift_in) p = k + 1;
    end
    for (int k = 0; k < WIN; k++) begin
      if (k < p)       nsrt[k] = tmp[(k < WIN - 1) ? k : WIN - 2];
      else if (k == p) nsrt[k] = shift_in;
      else             nsrt[k] = tmp[(k > 0) ? k - 1 : 0];
    end
`ifdef SMF_MODE_EN
    case (bus.mode)
      2'd1:    sel = nsrt[0];
      2'd2:    sel = nsrt[WIN-1];
      default: sel = nsrt[H];
    endcase
`else
    sel = nsrt[H];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < WIN; k++) begin
        win[k] <= '0;
        srt[k] <= '0;
      end
      cnt           <= '0;
      fcnt          <= '0;
      state         <= RUN;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.Dout      <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        RUN: begin
          if (bus.in_en) begin
            win[0] <= shift_in;
            for (int k = 1; k < WIN; k++) win[k] <= win[k-1];
            for (int k = 0; k < WIN; k++) srt[k] <= nsrt[k];
            if (cnt >= CW'(H)) begin
              bus.out_valid <= 1'b1;
              bus.Dout      <= sel;
            end
            if (cnt == CW'(LEN - 1)) begin
              state    <= FLUSH;
              bus.busy <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          bus.out_valid <= 1'b1;
          bus.Dout      <= sel;
          if (fcnt == FW'(H - 1)) begin
            // Last padding zero: start the next row from an all-zero window.
            for (int k = 0; k < WIN; k++) begin
              win[k] <= '0;
              srt[k] <= '0;
            end
            fcnt     <= '0;
            cnt      <= '0;
            state    <= RUN;
            bus.busy <= 1'b0;
          end else begin
            win[0] <= shift_in;
            for (int k = 1; k < WIN; k++) win[k] <= win[k-1];
            for (int k = 0; k < WIN; k++) srt[k] <= nsrt[k];
            fcnt <= fcnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_median_filter.sv
// tb/tb_stream_median_filter.sv - bench for stream_median_filter: sorted-window reference model plus pinned rows
// Two instances: WIN=3/LEN=8 and WIN=7/LEN=16; mode is exercised when SMF_MODE_EN is defined.
module tb_stream_median_filter;
  typedef logic [7:0] row_t [16];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_median_filter_if #(.DW(8)) if_a ();
  stream_median_filter_if #(.DW(8)) if_b ();

  stream_median_filter #(.DW(8), .WIN(3), .LEN(8))  dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  stream_median_filter #(.DW(8), .WIN(7), .LEN(16)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

  int checks = 0;
  int errors = 0;
  bit rnd_mode = 1'b0;
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  int bc_a = 0;
  int bc_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wof(input int u); return (u == 0) ? 3 : 7;  endfunction
  function automatic int lof(input int u); return (u == 0) ? 8 : 16; endfunction

  // Reference: rows recorded as accepted, outputs computed by sorting the padded window.
  logic [7:0] row [2][16];
  int idx [2];
  int fl [2];
  int fpos [2];
  bit ev [2];
  bit eb [2];
  logic [7:0] evv [2];
  int m_h;
  bit m_en;
  logic [7:0] m_d;

  function automatic int md_of(input int u);
`ifdef SMF_MODE_EN
    return (u == 0) ? int'(if_a.mode) : int'(if_b.mode);
`else
    return (u == 0) ? 0 : 0;
`endif
  endfunction

  function automatic logic [7:0] rank_of(input int u, input int i, input int md);
    logic [7:0] a [15];
    logic [7:0] t;
    int w, h, n, j;
    w = wof(u); h = (w - 1) / 2; n = lof(u);
    for (int k = 0; k < 15; k++) a[k] = 8'd0;
    for (int k = 0; k < w; k++) begin
      j = i - h + k;
      a[k] = (j < 0 || j >= n) ? 8'd0 : row[u][j];
    end
    for (int x = 0; x < w; x++)
      for (int y = 0; y < w - 1 - x; y++)
        if (a[y] > a[y+1]) begin t = a[y]; a[y] = a[y+1]; a[y+1] = t; end
    if (md == 1) return a[0];
    if (md == 2) return a[w-1];
    return a[h];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int u = 0; u < 2; u++) begin
        idx[u] = 0; fl[u] = 0; fpos[u] = 0; ev[u] = 0; eb[u] = 0; evv[u] = 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        m_h  = (wof(u) - 1) / 2;
        m_en = (u == 0) ? if_a.in_en : if_b.in_en;
        m_d  = (u == 0) ? if_a.Din : if_b.Din;
        ev[u] = 0;
        if (fl[u] > 0) begin
          evv[u] = rank_of(u, fpos[u], md_of(u));
          ev[u] = 1; fpos[u]++; fl[u]--;
          if (fl[u] == 0) idx[u] = 0;
        end else if (m_en) begin
          row[u][idx[u]] = m_d;
          if (idx[u] >= m_h) begin
            evv[u] = rank_of(u, idx[u] - m_h, md_of(u));
            ev[u] = 1;
          end
          if (idx[u] == lof(u) - 1) begin
            fl[u] = m_h; fpos[u] = lof(u) - m_h;
          end else idx[u]++;
        end
        eb[u] = (fl[u] > 0);
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("a_out_valid", if_a.out_valid, ev[0]);
      chk("a_busy", if_a.busy, eb[0]);
      if (ev[0]) chk("a_dout", if_a.Dout, evv[0]);
      chk("b_out_valid", if_b.out_valid, ev[1]);
      chk("b_busy", if_b.busy, eb[1]);
      if (ev[1]) chk("b_dout", if_b.Dout, evv[1]);
      if (if_a.out_valid) got_a.push_back(if_a.Dout);
      if (if_b.out_valid) got_b.push_back(if_b.Dout);
      if (if_a.busy) bc_a++;
      if (if_b.busy) bc_b++;
    end
  end

  task automatic drive(input int u, input bit en, input logic [7:0] d);
    if (u == 0) begin
      if_a.in_en = en; if_a.Din = d;
`ifdef SMF_MODE_EN
      if (rnd_mode) if_a.mode = 2'($urandom_range(3, 0));
`endif
    end else begin
      if_b.in_en = en; if_b.Din = d;
`ifdef SMF_MODE_EN
      if (rnd_mode) if_b.mode = 2'($urandom_range(3, 0));
`endif
    end
  endtask

  function automatic bit busy_of(input int u);
    return (u == 0) ? if_a.busy : if_b.busy;
  endfunction

  // gap: 0 none, 1 one idle cycle between accepts, 2 random idles.
  // tail: 0 leave in_en for a back-to-back row, 1 drop, 2 hold in_en high through busy then drop.
  task automatic send_row(input int u, input row_t s, input int cnt, input int gap, input int tail);
    int tries;
    for (int j = 0; j < cnt; j++) begin
      if (gap == 1 && j > 0) begin
        @(negedge clk); drive(u, 1'b0, 8'hee);
      end else if (gap == 2) begin
        while ($urandom_range(99, 0) < 30) begin @(negedge clk); drive(u, 1'b0, 8'($urandom)); end
      end
      tries = 0;
      do begin
        @(negedge clk); drive(u, 1'b1, s[j]); tries++;
      end while (busy_of(u) && tries < 40);
      if (tries >= 40) begin
        errors++;
        $display("FAIL accept_bound: unit %0d still busy after %0d cycles", u, tries);
      end
    end
    if (tail == 2) begin
      tries = 0;
      forever begin
        @(negedge clk);
        if (busy_of(u) && tries < 40) begin drive(u, 1'b1, 8'($urandom)); tries++; end
        else break;
      end
      drive(u, 1'b0, 8'd0);
    end else if (tail == 1) begin
      @(negedge clk); drive(u, 1'b0, 8'd0);
    end
  endtask

  task automatic idle(input int u);
    int t;
    drive(u, 1'b0, 8'd0);
    t = 0;
    do begin @(negedge clk); t++; end while (busy_of(u) && t < 50);
    if (t >= 50) begin
      errors++;
      $display("FAIL idle_bound: unit %0d busy never fell", u);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pin_a(input string nm, input row_t exp);
    chk({nm, "_count"}, got_a.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < got_a.size()) chk($sformatf("%s_out%0d", nm, k), got_a[k], exp[k]);
  endtask

  function automatic row_t rand_row(input int kind);
    row_t r;
    for (int k = 0; k < 16; k++) begin
      case (kind)
        0:       r[k] = 8'($urandom);
        1:       r[k] = 8'($urandom_range(3, 0) * 4);
        default: r[k] = ($urandom_range(2, 0) == 0) ? 8'd0 : (($urandom_range(1, 0) == 0) ? 8'd255 : 8'd128);
      endcase
    end
    return r;
  endfunction

  task automatic random_rows(input int u, input int n);
    for (int r = 0; r < n; r++)
      send_row(u, rand_row($urandom_range(2, 0)), lof(u), $urandom_range(2, 0),
               (r == n - 1) ? 1 : $urandom_range(2, 0));
    idle(u);
  endtask

  row_t r26, lit_med, lit_max, lit_min, all255;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    r26     = '{10, 50, 20, 80, 30, 30, 90, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    lit_med = '{10, 20, 50, 30, 30, 30, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    lit_max = '{50, 50, 80, 80, 80, 90, 90, 90, 0, 0, 0, 0, 0, 0, 0, 0};
    lit_min = '{0, 10, 20, 20, 30, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 16; k++) all255[k] = 8'd255;
    reset = 1'b0;
    drive(0, 1'b0, 8'd0);
    drive(1, 1'b0, 8'd0);
`ifdef SMF_MODE_EN
    if_a.mode = 2'd0;
    if_b.mode = 2'd0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_a_out_valid", if_a.out_valid, 0);
    chk("rst_a_busy", if_a.busy, 0);
    chk("rst_a_dout", if_a.Dout, 0);
    chk("rst_b_out_valid", if_b.out_valid, 0);
    chk("rst_b_busy", if_b.busy, 0);
    chk("rst_b_dout", if_b.Dout, 0);
    #3 reset = 1'b1;

    got_a.delete(); bc_a = 0;
    send_row(0, r26, 8, 0, 1);
    idle(0);
    pin_a("median_row", lit_med);
    chk("median_row_busy_cycles", bc_a, 1);

`ifdef SMF_MODE_EN
    if_a.mode = 2'd2;
    got_a.delete();
    send_row(0, r26, 8, 0, 1); idle(0);
    pin_a("max_row", lit_max);
    if_a.mode = 2'd1;
    got_a.delete();
    send_row(0, r26, 8, 0, 1); idle(0);
    pin_a("min_row", lit_min);
    if_a.mode = 2'd3;
    got_a.delete();
    send_row(0, r26, 8, 0, 1); idle(0);
    pin_a("mode3_row", lit_med);
    if_a.mode = 2'd0;
`endif

    got_a.delete(); bc_a = 0;
    send_row(0, r26, 8, 1, 2);
    idle(0);
    pin_a("gapped_row", lit_med);
    chk("gapped_row_busy_cycles", bc_a, 1);

    got_b.delete(); bc_b = 0;
    send_row(1, all255, 16, 0, 0);
    send_row(1, all255, 16, 0, 1);
    idle(1);
    chk("sat_count", got_b.size(), 32);
    for (int k = 0; k < got_b.size(); k++) chk($sformatf("sat_out%0d", k), got_b[k], 255);
    chk("sat_busy_cycles", bc_b, 6);

    send_row(0, r26, 4, 0, 0);
    @(posedge clk);
    #2 drive(0, 1'b0, 8'd0);
    reset = 1'b0;
    #1;
    chk("midrow_rst_out_valid", if_a.out_valid, 0);
    chk("midrow_rst_busy", if_a.busy, 0);
    chk("midrow_rst_dout", if_a.Dout, 0);
    @(negedge clk);
    #3 reset = 1'b1;
    got_a.delete();
    send_row(0, r26, 8, 0, 1);
    idle(0);
    pin_a("after_rst_row", lit_med);

    rnd_mode = 1'b1;
    fork
      random_rows(0, 25);
      random_rows(1, 20);
    join
    rnd_mode = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
